// File: rtl/uart_rx_line_buf_pkg.sv
// +--------------------------------------------------------------------------+
// | uart_rx_pkg : shared types and helpers for the UART line receiver        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package uart_rx_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic {
    LINE_FILL,
    LINE_DRAIN
  } line_state_e;

  localparam int OversampleRate  = 16;
  localparam int StartSampleTick = 8;

  // Expected parity bit for a (zero-extended) character.
  function automatic logic calc_parity(input logic [8:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_line_buf_core.sv
// +--------------------------------------------------------------------------+
// | uart_rx_core : rx synchroniser, oversample tick generator and RX FSM     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_core
  import uart_rx_pkg::*;
#(
  parameter int DataBits    = 8,
  parameter int ParityEna   = 0,
  parameter int ParityOdd   = 0,
  parameter int ClkDivWidth = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ClkDivWidth-1:0] baud_div,
  input  logic                   rx,
  output logic                   tick,
  output logic                   char_valid,
  output logic [DataBits-1:0]    char_data,
  output logic                   parity_err,
  output logic                   frame_err,
  output logic                   busy
);

  localparam logic [3:0] StartLast = 4'(StartSampleTick - 1);
  localparam logic [3:0] OsLast    = 4'(OversampleRate - 1);
  localparam logic [3:0] BitLast   = 4'(DataBits - 1);

  logic                   rx_meta;
  logic                   rx_sync;
  logic [ClkDivWidth-1:0] div_q;
  logic [ClkDivWidth-1:0] tick_cnt;
  rx_state_e              state;
  logic [3:0]             os_cnt;
  logic [3:0]             bit_cnt;
  logic [DataBits-1:0]    shreg;
  logic                   par_bad;
  logic                   start_det;
  logic                   os_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign start_det = (state == RX_IDLE) && !rx_sync;
  assign tick      = (tick_cnt == div_q);
  assign os_last   = (os_cnt == OsLast);
  assign busy      = (state != RX_IDLE);

  // Divisor is captured at the start edge so a mid-frame change waits a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      tick_cnt <= '0;
    end else if (start_det) begin
      div_q    <= baud_div;
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RX_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bad    <= 1'b0;
      char_valid <= 1'b0;
      char_data  <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        RX_IDLE: begin
          os_cnt  <= '0;
          bit_cnt <= '0;
          par_bad <= 1'b0;
          if (!rx_sync) state <= RX_START;
        end
        RX_START: if (tick) begin
          if (os_cnt == StartLast) begin
            os_cnt <= '0;
            state  <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            os_cnt <= os_cnt + 4'd1;
          end
        end
        // os_cnt wraps 15 -> 0 on its own, giving one sample per bit time.
        RX_DATA: if (tick) begin
          os_cnt <= os_cnt + 4'd1;
          if (os_last) begin
            shreg   <= {rx_sync, shreg[DataBits-1:1]};
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == BitLast) state <= (ParityEna != 0) ? RX_PARITY : RX_STOP;
          end
        end
        RX_PARITY: if (tick) begin
          os_cnt <= os_cnt + 4'd1;
          if (os_last) begin
            par_bad <= (rx_sync != calc_parity(9'(shreg), ParityOdd != 0));
            state   <= RX_STOP;
          end
        end
        RX_STOP: if (tick) begin
          os_cnt <= os_cnt + 4'd1;
          if (os_last) begin
            if (!rx_sync) begin
              frame_err <= 1'b1;
              state     <= RX_WAIT_HIGH;
            end else if (par_bad) begin
              parity_err <= 1'b1;
              state      <= RX_IDLE;
            end else begin
              char_valid <= 1'b1;
              char_data  <= shreg;
              state      <= RX_IDLE;
            end
          end
        end
        RX_WAIT_HIGH: if (rx_sync) state <= RX_IDLE;
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_line_buf.sv
// +--------------------------------------------------------------------------+
// | uart_rx_line_buf : UART receiver assembling characters into lines,       |
// | read out as a valid/ready stream. Optional UART_RX_LINE_TIMEOUT_EN adds  |
// | an idle flush of partial lines.                       Rev 1.0            |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_line_buf
  import uart_rx_pkg::*;
#(
  parameter int          DataBits    = 8,
  parameter int          ParityEna   = 0,
  parameter int          ParityOdd   = 0,
  parameter int          LineDepth   = 80,
  parameter int unsigned EolChar     = 32'h0A,
  parameter int          ClkDivWidth = 16,
  parameter int          IdleTimeout = 160
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [ClkDivWidth-1:0]         baud_div_i,
  input  logic                           rx_i,
  output logic                           char_valid_o,
  input  logic                           char_ready_i,
  output logic [DataBits-1:0]            char_data_o,
  output logic                           char_last_o,
  output logic                           line_valid_o,
  output logic [$clog2(LineDepth+1)-1:0] line_len_o,
  output logic                           parity_err_o,
  output logic                           frame_err_o,
  output logic                           overrun_o,
  output logic                           line_timeout_o,
  output logic                           busy_o
);

  localparam int                  CntW     = $clog2(LineDepth + 1);
  localparam int                  AddrW    = $clog2(LineDepth);
  localparam logic [DataBits-1:0] EolMatch = EolChar[DataBits-1:0];

  logic                rx_tick;
  logic                rx_commit;
  logic [DataBits-1:0] rx_data;
  logic                rx_busy;

  uart_rx_core #(
    .DataBits   (DataBits),
    .ParityEna  (ParityEna),
    .ParityOdd  (ParityOdd),
    .ClkDivWidth(ClkDivWidth)
  ) u_core (
    .clk       (clk_i),
    .rst       (rst_i),
    .baud_div  (baud_div_i),
    .rx        (rx_i),
    .tick      (rx_tick),
    .char_valid(rx_commit),
    .char_data (rx_data),
    .parity_err(parity_err_o),
    .frame_err (frame_err_o),
    .busy      (rx_busy)
  );

  assign busy_o = rx_busy;

  line_state_e         line_state;
  logic [CntW-1:0]     count;
  logic [CntW-1:0]     rd_idx;
  logic [DataBits-1:0] mem [LineDepth];
  logic                timed_out;
  logic                draining;
  logic                hs;
  logic                last_rd;
  logic                wrap;
  logic                wr_en;
  logic [CntW-1:0]     wr_addr;
  logic                timeout_hit;

  always_comb begin
    draining = (line_state == LINE_DRAIN);
    hs       = draining && char_ready_i;
    last_rd  = (rd_idx == count - 1'b1);
    wrap     = hs && last_rd;
    // A commit racing the final handshake opens the next line at index 0.
    wr_en    = rx_commit && (!draining || wrap);
    wr_addr  = draining ? '0 : count;
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[AddrW'(wr_addr)] <= rx_data;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      line_state <= LINE_FILL;
      count      <= '0;
      rd_idx     <= '0;
      overrun_o  <= 1'b0;
      timed_out  <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      case (line_state)
        LINE_FILL: begin
          if (rx_commit) begin
            count <= count + 1'b1;
            if (rx_data == EolMatch || count + 1'b1 == CntW'(LineDepth)) begin
              line_state <= LINE_DRAIN;
              rd_idx     <= '0;
            end
          end else if (timeout_hit) begin
            line_state <= LINE_DRAIN;
            rd_idx     <= '0;
            timed_out  <= 1'b1;
          end
        end
        LINE_DRAIN: begin
          if (wrap) begin
            rd_idx    <= '0;
            timed_out <= 1'b0;
            if (rx_commit) begin
              count      <= CntW'(1);
              line_state <= (rx_data == EolMatch) ? LINE_DRAIN : LINE_FILL;
            end else begin
              count      <= '0;
              line_state <= LINE_FILL;
            end
          end else begin
            if (hs) rd_idx <= rd_idx + 1'b1;
            if (rx_commit) overrun_o <= 1'b1;
          end
        end
        default: line_state <= LINE_FILL;
      endcase
    end
  end

  assign char_valid_o   = draining;
  assign char_data_o    = draining ? mem[AddrW'(rd_idx)] : '0;
  assign char_last_o    = draining && last_rd;
  assign line_valid_o   = draining;
  assign line_len_o     = draining ? count : '0;
  assign line_timeout_o = timed_out;

`ifdef UART_RX_LINE_TIMEOUT_EN
  localparam int ToW = $clog2(IdleTimeout + 1);

  logic [ToW-1:0] idle_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
    end else if (draining || count == '0 || rx_busy) begin
      idle_cnt <= '0;
    end else if (rx_tick) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout_hit = !draining && count != '0 && !rx_busy && rx_tick &&
                       idle_cnt == ToW'(IdleTimeout - 1);
`else
  logic unused_timeout;
  assign unused_timeout = rx_tick ^ (IdleTimeout != 0);
  assign timeout_hit    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_line_buf.sv
// +--------------------------------------------------------------------------+
// | tb_uart_rx_line_buf : scoreboard bench for uart_rx_line_buf              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_line_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] baud_div = 16'd4;
  logic        rx = 1'b1;
  logic        rx_p = 1'b1;
  logic        ready = 1'b0;
  logic        ready_p = 1'b0;
  int          bit_clks = 80;

  logic       cv, cl, lv, pe, fe, ov, lt, busy;
  logic [7:0] cd;
  logic [6:0] ll;
  logic       cv_p, cl_p, lv_p, pe_p, fe_p, ov_p, lt_p, busy_p;
  logic [7:0] cd_p;
  logic [2:0] ll_p;

  int checks = 0;
  int failures = 0;
  int n_fe = 0, n_pe = 0, n_ov = 0, n_pe_p = 0;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         len;
    logic       to;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  uart_rx_line_buf dut (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .rx_i(rx),
    .char_valid_o(cv), .char_ready_i(ready), .char_data_o(cd), .char_last_o(cl),
    .line_valid_o(lv), .line_len_o(ll), .parity_err_o(pe), .frame_err_o(fe),
    .overrun_o(ov), .line_timeout_o(lt), .busy_o(busy)
  );

  uart_rx_line_buf #(.ParityEna(1), .ParityOdd(0), .LineDepth(4)) dut_p (
    .clk_i(clk), .rst_i(rst), .baud_div_i(baud_div), .rx_i(rx_p),
    .char_valid_o(cv_p), .char_ready_i(ready_p), .char_data_o(cd_p), .char_last_o(cl_p),
    .line_valid_o(lv_p), .line_len_o(ll_p), .parity_err_o(pe_p), .frame_err_o(fe_p),
    .overrun_o(ov_p), .line_timeout_o(lt_p), .busy_o(busy_p)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every accepted character is matched in order.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (fe) n_fe++;
      if (pe) n_pe++;
      if (ov) n_ov++;
      if (pe_p) n_pe_p++;
      if (cv && ready) begin
        if (sb.size() == 0) begin
          check_eq("sb_nonempty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check_eq("char_data", cd, e.d);
          check_eq("char_last", cl, e.last);
          check_eq("line_len", ll, e.len);
          check_eq("line_timeout", lt, e.to);
        end
      end
    end
  end

  task automatic drive_bit(input bit sel, input bit v);
    if (sel) rx_p = v;
    else rx = v;
    repeat (bit_clks) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                            input bit par, input bit stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, par);
    drive_bit(sel, stop);
  endtask

  task automatic push(input logic [7:0] d, input logic last, input int len, input logic to);
    exp_t e;
    e.d = d; e.last = last; e.len = len; e.to = to;
    sb.push_back(e);
  endtask

  task automatic wait_sb_empty(input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) @(negedge clk);
    check_eq("sb_drained", sb.size(), 0);
  endtask

  task automatic set_baud(input logic [15:0] d);
    baud_div = d;
    bit_clks = (int'(d) + 1) * 16;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 ready = v;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    bit seen_busy;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {cv, cd, cl, lv, ll, pe, fe, ov, lt, busy}, 0);
    check_eq("rst_outs_p", {cv_p, lv_p, ll_p, busy_p, lt_p}, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic line "Hi\n"
    set_baud(16'd4);
    set_ready(1'b1);
    push(8'h48, 1'b0, 3, 1'b0);
    push(8'h69, 1'b0, 3, 1'b0);
    push(8'h0A, 1'b1, 3, 1'b0);
    send_frame(0, 8'h48, 0, 0, 1);
    send_frame(0, 8'h69, 0, 0, 1);
    send_frame(0, 8'h0A, 0, 0, 1);
    wait_sb_empty(200);
    check_eq("basic_errs", n_fe + n_pe + n_ov, 0);

    // Full line with consumer stalled: char 81 overruns
    set_baud(16'd0);
    set_ready(1'b0);
    for (int i = 0; i < 80; i++) push(8'h41, i == 79, 80, 1'b0);
    for (int i = 0; i < 81; i++) send_frame(0, 8'h41, 0, 0, 1);
    @(negedge clk);
    check_eq("full_valid", lv, 1);
    check_eq("full_len", ll, 80);
    check_eq("full_overrun", n_ov, 1);
    set_ready(1'b1);
    wait_sb_empty(500);

    // Full line with consumer ready: char 81 opens a new line
    for (int i = 0; i < 80; i++) push(8'h41, i == 79, 80, 1'b0);
    push(8'h41, 1'b0, 2, 1'b0);
    push(8'h0A, 1'b1, 2, 1'b0);
    for (int i = 0; i < 81; i++) send_frame(0, 8'h41, 0, 0, 1);
    send_frame(0, 8'h0A, 0, 0, 1);
    wait_sb_empty(500);
    check_eq("full2_overrun", n_ov, 1);

    // Start-bit glitch
    seen_busy = 1'b0;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seen_busy |= busy;
    end
    check_eq("glitch_busy_seen", seen_busy, 1);
    check_eq("glitch_busy_idle", busy, 0);
    check_eq("glitch_errs", n_fe + n_pe, 0);

    // Bad stop bit, then break, then a clean EOL
    send_frame(0, 8'h55, 0, 0, 0);
    drive_bit(0, 1'b1);
    check_eq("frame_err_cnt", n_fe, 1);
    check_eq("frame_nothing_held", lv, 0);
    rx = 1'b0;
    repeat (20 * bit_clks) @(negedge clk);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b1);
    check_eq("break_err_cnt", n_fe, 2);
    push(8'h0A, 1'b1, 1, 1'b0);
    send_frame(0, 8'h0A, 0, 0, 1);
    wait_sb_empty(100);

    // Reset in the middle of the second character
    set_baud(16'd4);
    send_frame(0, 8'h41, 0, 0, 1);
    drive_bit(0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, i == 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_outs", {cv, cd, cl, lv, ll, pe, fe, ov, lt, busy}, 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    push(8'h4F, 1'b0, 3, 1'b0);
    push(8'h4B, 1'b0, 3, 1'b0);
    push(8'h0A, 1'b1, 3, 1'b0);
    send_frame(0, 8'h4F, 0, 0, 1);
    send_frame(0, 8'h4B, 0, 0, 1);
    send_frame(0, 8'h0A, 0, 0, 1);
    wait_sb_empty(200);

    // Even parity instance: 0x07 needs parity bit 1, 0x0A needs 0
    set_baud(16'd0);
    send_frame(1, 8'h07, 1, 0, 1);
    check_eq("parity_err_cnt", n_pe_p, 1);
    check_eq("parity_not_held", lv_p, 0);
    send_frame(1, 8'h07, 1, 1, 1);
    send_frame(1, 8'h0A, 1, 0, 1);
    for (int i = 0; i < 50 && !lv_p; i++) @(negedge clk);
    check_eq("par_line_valid", lv_p, 1);
    check_eq("par_line_len", ll_p, 2);
    check_eq("par_char0", cd_p, 8'h07);
    check_eq("par_last0", cl_p, 0);
    @(posedge clk);
    #1 ready_p = 1'b1;
    @(posedge clk);
    #1 ready_p = 1'b0;
    @(negedge clk);
    check_eq("par_char1", cd_p, 8'h0A);
    check_eq("par_last1", cl_p, 1);
    @(posedge clk);
    #1 ready_p = 1'b1;
    @(posedge clk);
    #1 ready_p = 1'b0;
    @(negedge clk);
    check_eq("par_drained", lv_p, 0);
    check_eq("par_err_total", n_pe_p, 1);

`ifdef UART_RX_LINE_TIMEOUT_EN
    // Idle flush of a partial line
    set_baud(16'd4);
    push(8'h41, 1'b0, 2, 1'b1);
    push(8'h42, 1'b1, 2, 1'b1);
    send_frame(0, 8'h41, 0, 0, 1);
    send_frame(0, 8'h42, 0, 0, 1);
    wait_sb_empty(1500);
    @(negedge clk);
    check_eq("timeout_cleared", lt, 0);
`endif

    check_eq("main_err_total", {n_fe[15:0], n_pe[7:0], n_ov[7:0]}, {16'd2, 8'd0, 8'd1});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
